// File: rtl/imem_boot_arbiter.sv
// Instruction memory port arbiter: fetch unit in RUN, UART boot loader otherwise.
// Optional checksum output enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int IDLE_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              boot_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done,
  output logic              err
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [2:0] {
    RUN,
    ARM,
    LOAD,
    WRITE,
    DRAIN
  } state_e;

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE =
    {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic              req_q;
  logic              req_vld_q;
  logic [ADDR_W:0]   ptr_q;
  logic [1:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [23:0]       part_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              hold_q;
  logic              busy_q;
  logic [ADDR_W:0]   wl_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       chk_q;

  logic              rise_d;
  logic              full_d;
  logic [31:0]       word_d;

  // The first sample after reset only seeds the history, so a level
  // held high through reset never looks like a fresh request.
  assign rise_d = boot_req & ~req_q & req_vld_q;
  assign full_d = (ptr_q == DEPTH);
  assign word_d = {part_q, rx_data};

  assign imem_addr = (state_q == RUN) ? fetch_addr
                                      : ptr_q[ADDR_W-1:0];
  assign imem_we      = we_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign words_loaded = wl_q;
  assign done         = done_q;
  assign err          = err_q;

`ifdef IMEM_BOOT_CHECKSUM_EN
  assign checksum = chk_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      req_q     <= 1'b0;
      req_vld_q <= 1'b0;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      part_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      wl_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      chk_q     <= '0;
    end else begin
      req_q     <= boot_req;
      req_vld_q <= 1'b1;
      done_q    <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (rise_d) begin
            state_q <= ARM;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wl_q    <= '0;
            err_q   <= 1'b0;
            chk_q   <= '0;
          end
        end
        ARM: begin
          if (rx_valid) begin
            part_q  <= {part_q[15:0], rx_data};
            idx_q   <= 2'd1;
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            cnt_q  <= '0;
            part_q <= {part_q[15:0], rx_data};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (full_d) begin
                err_q <= 1'b1;
              end else begin
                wdata_q <= word_d;
                we_q    <= 1'b1;
                state_q <= WRITE;
              end
            end
          end else if (cnt_q == IDLE_LAST) begin
            if (idx_q != 2'd0) err_q <= 1'b1;
            idx_q   <= '0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          ptr_q   <= ptr_q + ONE;
          wl_q    <= wl_q + ONE;
          chk_q   <= chk_q ^ wdata_q;
          state_q <= LOAD;
          if (rx_valid) begin
            part_q <= {part_q[15:0], rx_data};
            idx_q  <= idx_q + 2'd1;
            cnt_q  <= '0;
          end
        end
        DRAIN: begin
          state_q <= RUN;
          hold_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter: run-mode vector table
// plus hand-written boot, overflow, reset and edge-detect sequences.
module tb_imem_boot_arbiter;

  localparam int AW = 4;
  localparam int IC = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          boot_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] fetch_addr = '0;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic [AW:0]   words_loaded;
  logic          done;
  logic          err;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_boot_arbiter #(
    .ADDR_W(AW),
    .IDLE_CYCLES(IC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .boot_req(boot_req),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .fetch_addr(fetch_addr),
    .imem_addr(imem_addr),
    .imem_we(imem_we),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .words_loaded(words_loaded),
    .done(done),
    .err(err)
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  logic [31:0] mem [16];
  always @(posedge clock) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] fa;
    logic          rv;
    logic [7:0]    rd;
    logic [AW-1:0] ea;
    logic          ewe;
    logic          ehold;
    logic          ebusy;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
  endtask

  task automatic wait_done(input string nm,
                           input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'd5,  1'b0, 8'h00, 4'd5,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd0,  1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'd15, 1'b1, 8'hA5, 4'd15, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'd9,  1'b1, 8'h3C, 4'd9,  1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'd6,  1'b0, 8'h00, 4'd6,  1'b0, 1'b0, 1'b0};

    // reset state
    fetch_addr = 4'd5;
    repeat (3) tick();
    #1;
    chk("rst_addr", {28'd0, imem_addr}, 32'd5);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_wl", {27'd0, words_loaded}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick();

    // run-mode table: mux follows fetch, rx ignored
    for (int i = 0; i < 5; i++) begin
      fetch_addr = tbl[i].fa;
      rx_valid   = tbl[i].rv;
      rx_data    = tbl[i].rd;
      tick();
      chk($sformatf("run%0d_addr", i),
          {28'd0, imem_addr}, {28'd0, tbl[i].ea});
      chk($sformatf("run%0d_we", i),
          {31'd0, imem_we}, {31'd0, tbl[i].ewe});
      chk($sformatf("run%0d_hold", i),
          {31'd0, cpu_hold}, {31'd0, tbl[i].ehold});
      chk($sformatf("run%0d_busy", i),
          {31'd0, busy}, {31'd0, tbl[i].ebusy});
    end
    rx_valid = 1'b0;
    chk("run_wdata", imem_wdata, 32'd0);

    // boot of two words
    fetch_addr = 4'd5;
    pulse_boot();
    chk("arm_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_addr", {28'd0, imem_addr}, 32'd0);
    begin
      logic [7:0] bs [8];
      bs = '{8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0};
      for (int i = 0; i < 8; i++) begin
        send(bs[i]);
        if (i == 3) begin
          chk("w0_we", {31'd0, imem_we}, 32'd1);
          chk("w0_addr", {28'd0, imem_addr}, 32'd0);
          chk("w0_data", imem_wdata, 32'h12345678);
        end
      end
    end
    tick();
    repeat (16) tick();
    chk("drain_hold", {31'd0, cpu_hold}, 32'd1);
    chk("drain_done", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_wl", {27'd0, words_loaded}, 32'd2);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_m0", mem[0], 32'h12345678);
    chk("t1_m1", mem[1], 32'h9ABCDEF0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    chk("t1_csum", checksum, 32'h88888888);
`endif
    tick();
    chk("t1_pulse", {31'd0, done}, 32'd0);

    // partial trailing word
    pulse_boot();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    wait_done("t2_done", 40);
    chk("t2_m0", mem[0], 32'h11223344);
    chk("t2_m1", mem[1], 32'h9ABCDEF0);
    chk("t2_wl", {27'd0, words_loaded}, 32'd1);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    chk("t2_csum", checksum, 32'h11223344);
`endif

    // overflow: 17 words into 16-word memory
    pulse_boot();
    chk("t3_errclr", {31'd0, err}, 32'd0);
    for (int k = 0; k < 17; k++) begin
      send(8'(k));
      send(8'hC0);
      send(8'hDE);
      send(8'(k));
    end
    chk("t3_full_err", {31'd0, err}, 32'd1);
    chk("t3_full_we", {31'd0, imem_we}, 32'd0);
    wait_done("t3_done", 40);
    chk("t3_wl", {27'd0, words_loaded}, 32'd16);
    chk("t3_m0", mem[0], 32'h00C0DE00);
    chk("t3_m15", mem[15], 32'h0FC0DE0F);

    // reset mid-boot, boot_req during LOAD ignored
    fetch_addr = 4'd7;
    pulse_boot();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    send(8'h01);
    send(8'h02);
    pulse_boot();
    tick();
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_wl", {27'd0, words_loaded}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t4_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t4_rbusy", {31'd0, busy}, 32'd0);
    chk("t4_addr", {28'd0, imem_addr}, 32'd7);
    chk("t4_m0", mem[0], 32'hAABBCCDD);

    // boot_req held high across reset release
    boot_req = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t5_noboot", {31'd0, busy}, 32'd0);
    boot_req = 1'b0;
    tick();
    boot_req = 1'b1;
    tick();
    chk("t5_boot", {31'd0, busy}, 32'd1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        tick();
        if (done) seen = 1'b1;
      end
      chk("t5_arm_wait", {31'd0, busy}, 32'd1);
      chk("t5_no_done", {31'd0, seen}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_arbiter.md
Name: imem_boot_arbiter

Overview:
- Owns the single port of the instruction memory and shares it between two users: the instruction fetch unit (run mode) and a UART program loader (boot mode).
- In boot mode it holds the CPU, assembles received bytes into 32-bit words and writes them to consecutive word addresses from 0.
- Boot ends on an idle timeout. The CPU is then released so fetch restarts from PC 0.

Parameters:
- ADDR_W, 14, instruction memory word-address width; DEPTH = 2**ADDR_W words.
- IDLE_CYCLES, 100000, consecutive cycles with rx_valid low in LOAD that end the boot.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- boot_req  in  1  level request for boot mode; acted on at its rising edge.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- fetch_addr  in  ADDR_W  word address from the fetch unit (PC[ADDR_W+1:2]).
- imem_addr  out  ADDR_W  address driven to instruction memory.
- imem_we  out  1  write enable to instruction memory.
- imem_wdata  out  32  write data to instruction memory.
- cpu_hold  out  1  high = fetch unit held in reset.
- busy  out  1  high in any state other than RUN.
- words_loaded  out  ADDR_W+1  count of words committed in the current/last boot.
- done  out  1  one-cycle pulse when a boot completes.
- err  out  1  sticky error flag; cleared on entry to ARM.

Behaviour:
- Reset values: state=RUN, imem_we=0, imem_wdata=0, cpu_hold=0, busy=0, words_loaded=0, done=0, err=0, write pointer=0, byte index=0, idle counter=0. boot_req edge register=0.
- boot_req edge detect: uses a registered copy of boot_req. A request held high across reset does not trigger until it is released and raised again.
- Port mux: imem_addr = fetch_addr in RUN, otherwise the write pointer. imem_we is high only in WRITE.
- RUN: cpu_hold=0. A boot_req rising edge moves to ARM in the next cycle. rx_valid is ignored in RUN.
- ARM: cpu_hold=1, busy=1.
  - On entry, clears pointer, byte index, words_loaded and err.
  - Waits indefinitely for the first byte; there is no timeout in ARM.
  - The first rx_valid captures byte 0 and moves to LOAD.
- LOAD: bytes are packed big-endian: byte0 -> [31:24] ... byte3 -> [7:0].
  - The 4th byte latches the assembled word into imem_wdata and moves to WRITE.
  - The idle counter increments each cycle with rx_valid low and clears on rx_valid.
  - When the counter reaches IDLE_CYCLES, go to DRAIN.
- WRITE: exactly one cycle, imem_we=1 at the write pointer. Next cycle: pointer+1, words_loaded+1, return to LOAD.
  - A byte arriving during WRITE is captured as byte0 of the next word; it is never dropped.
  - WRITE does not advance the idle counter.
- Full: if the pointer equals DEPTH at the 4th byte, the write is suppressed, err is set and the state stays in LOAD. Later bytes are discarded; the timeout still ends the boot. words_loaded saturates at DEPTH.
- Partial word at timeout (byte index 1..3): the partial bytes are discarded and err is set.
- DRAIN: one cycle with cpu_hold=1. Then go to RUN, pulse done for 1 cycle and drop cpu_hold in the same cycle done is high.
- boot_req rising edge while busy: ignored.
- reset asserted mid-boot: immediate return to RUN with reset values. Words already written stay in memory.
- imem_wdata holds its last value in RUN. Memory ignores it because imem_we=0.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- With the macro: adds output port checksum (32 bits). It is the XOR of every word committed by a WRITE in the current boot. It clears on entry to ARM and updates in the same cycle as words_loaded. It resets to 0 and holds after done.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan (IDLE_CYCLES=16, ADDR_W=4):
- After reset, with fetch_addr=5 -> imem_addr=5, imem_we=0, cpu_hold=0, busy=0.
- Pulse boot_req, then send bytes 12 34 56 78 9A BC DE F0, then go idle -> two writes: addr0=0x12345678, addr1=0x9ABCDEF0. done pulses 17 cycles after the last byte's WRITE returns to LOAD. words_loaded=2, err=0, cpu_hold falls with done. With the macro: checksum=0x88888888.
- Send bytes 11 22 33 44 55, then go idle -> one write of 0x11223344 to addr0, words_loaded=1, err=1, done pulses.
- Send 17 words back-to-back -> 16 writes at addr0..15, the 17th is not written, err=1, words_loaded=16.
- Assert reset after 2 bytes of the second word -> next cycle: cpu_hold=0, busy=0, state RUN; addr0 still holds the first word. A boot_req pulse during LOAD has no effect.
- Hold boot_req high through reset release -> no boot until boot_req goes low then high.
